fas_seq_ctrl: RTL

FAS_SEQ_CTRL -- requirements
Module: fas_seq_ctrl

---
 rtl/fas_pkg.sv | 19 +
 rtl/fas_timeout_cnt.sv | 32 +++
 rtl/fas_seq_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fas_pkg.sv
// rtl/fas_pkg.sv - shared FAS constants, FSM encoding and width helper
package fas_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam int DEF_FRAME_LEN = 16;
    localparam int DEF_TIMEOUT   = 1023;

    // Bits needed to count 0 .. n-1, never less than one
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fas_timeout_cnt.sv
// rtl/fas_timeout_cnt.sv - WAIT-phase cycle counter with expiry flag
module fas_timeout_cnt
    import fas_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    input  logic enable,
    output logic expire
);
    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Expiry fires in the cycle whose increment would make the count reach TIMEOUT
    assign expire = enable && (count == LAST);

    // Cleared whenever not timing, counts up while enabled
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fas_seq_ctrl.sv
// rtl/fas_seq_ctrl.sv - sequences sample frames into the FAS pipeline and collects results
module fas_seq_ctrl
    import fas_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [7:0]  num_frames,
    input  logic        src_valid,
    input  logic [15:0] src_data,
    output logic        src_ready,
    output logic        data_valid,
    output logic [15:0] data,
    input  logic        fas_done,
    input  logic [3:0]  fas_freq,
    output logic        res_valid,
    output logic [3:0]  res_freq,
    output logic [7:0]  res_idx,
    output logic        busy,
    output logic        all_done,
    output logic        timeout_err
);
    localparam int SW = cnt_width(FRAME_LEN);
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(FRAME_LEN - 1);

    state_t        state;
    state_t        state_n;
    logic [SW-1:0] sample_cnt;
    logic [7:0]    frame_idx;
    logic [7:0]    frame_total;
    logic          pending;
    logic [3:0]    pending_freq;
    logic          in_load;
    logic          in_wait;
    logic          handshake;
    logic          last_sample;
    logic          got_result;
    logic          more_frames;
    logic          tmr_expire;
    logic [3:0]    result_freq;

    assign in_load     = (state == ST_LOAD);
    assign in_wait     = (state == ST_WAIT);
    assign src_ready   = in_load;
    assign handshake   = src_valid && in_load;
    assign last_sample = handshake && (sample_cnt == LAST_SAMPLE);
    // A live fas_done in WAIT carries the freshest frequency; otherwise use the one held from LOAD
    assign got_result  = in_wait && (fas_done || pending);
    assign result_freq = fas_done ? fas_freq : pending_freq;
    // Widened to 9 bits so frame 255 cannot wrap the comparison
    assign more_frames = ({1'b0, frame_idx} + 9'd1) < {1'b0, frame_total};

    fas_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .load   (!in_wait),
        .enable (in_wait),
        .expire (tmr_expire)
    );

    // Next-state selection; a result outranks a simultaneous timer expiry
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = (num_frames != 8'd0) ? ST_LOAD : ST_FINISH;
                end
            end
            ST_LOAD: begin
                if (last_sample) begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (got_result) begin
                    state_n = more_frames ? ST_LOAD : ST_FINISH;
                end else if (tmr_expire) begin
                    state_n = ST_FINISH;
                end
            end
            ST_FINISH: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // State register with busy tracking the new state and all_done following FINISH
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            all_done <= 1'b0;
        end else begin
            state    <= state_n;
            busy     <= (state_n != ST_IDLE);
            all_done <= (state == ST_FINISH);
        end
    end

    // Sample forwarding with one-cycle latency and per-frame sample counting
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_valid <= 1'b0;
            data       <= '0;
            sample_cnt <= '0;
        end else begin
            data_valid <= handshake;
            if (handshake) begin
                data <= src_data;
            end
            if (state == ST_IDLE || last_sample) begin
                sample_cnt <= '0;
            end else if (handshake) begin
                sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end

    // Run bookkeeping, early fas_done capture, result record and timeout flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_total  <= '0;
            frame_idx    <= '0;
            pending      <= 1'b0;
            pending_freq <= '0;
            res_valid    <= 1'b0;
            res_freq     <= '0;
            res_idx      <= '0;
            timeout_err  <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (state == ST_IDLE) begin
                pending <= 1'b0;
                if (start && num_frames != 8'd0) begin
                    frame_total <= num_frames;
                    frame_idx   <= '0;
                    timeout_err <= 1'b0;
                end
            end
            if (in_load && fas_done) begin
                pending      <= 1'b1;
                pending_freq <= fas_freq;
            end
            if (got_result) begin
                res_valid <= 1'b1;
                res_freq  <= result_freq;
                res_idx   <= frame_idx;
                frame_idx <= frame_idx + 8'd1;
                pending   <= 1'b0;
            end else if (tmr_expire) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
